// File: rtl/eth_pkg.sv
// Shared MAC-side definitions for the TX FIFO reader: BE encoding, FSM states, header layout.
package eth_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned HDR_LEN_LSB = 0;

  // Tx_mac_BE encoding: number of valid bytes on the eop word.
  localparam logic [1:0] BE_4 = 2'b00;
  localparam logic [1:0] BE_1 = 2'b01;
  localparam logic [1:0] BE_2 = 2'b10;
  localparam logic [1:0] BE_3 = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StDrop,
    StDone
  } tx_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [1:0]        be;
  } tx_word_t;

  function automatic logic [1:0] be_for_len(input logic [1:0] len_lsb);
    case (len_lsb)
      2'd1:    return BE_1;
      2'd2:    return BE_2;
      2'd3:    return BE_3;
      default: return BE_4;
    endcase
  endfunction

endpackage

// File: rtl/tx_skid2.sv
// Two-entry FIFO between the packet FIFO read path and the MAC write port.
module tx_skid2
  import eth_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  tx_word_t   push_word_i,
  input  logic       pop_i,
  output tx_word_t   head_o,
  output logic [1:0] occ_o
);

  tx_word_t   mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] occ_q;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_word_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/mac_tx_fifo_reader.sv
// Drains length-prefixed frames from the packet read FIFO into the MAC user TX port.
module mac_tx_fifo_reader
  import eth_pkg::*;
#(
  parameter int unsigned MAX_LEN = 2047,
  parameter int unsigned LEN_W   = 16
) (
  input  logic        Clk_user,
  input  logic        Reset,
  input  logic [31:0] rd_dat_i,
  output logic        rd_read_o,
  output logic        rd_done_o,
  input  logic        rd_ready_i,
  input  logic        rd_empty_i,
  input  logic        Tx_mac_wa,
  output logic        Tx_mac_wr,
  output logic [31:0] Tx_mac_data,
  output logic [1:0]  Tx_mac_BE,
  output logic        Tx_mac_sop,
  output logic        Tx_mac_eop,
  output logic        err_o
);

  tx_state_t        state_q, state_d;
  logic [LEN_W-1:0] hdr_len, hdr_len_p3, hdr_words;
  logic             hdr_oversize;
  logic [1:0]       len_lsb_q;
  logic [LEN_W-1:0] words_q, reads_left_q, sent_left_q;
  logic             inflight_q, inf_sop_q, inf_eop_q;

  tx_word_t   head, push_word;
  logic [1:0] occ;
  logic       buf_valid, consume, can_read, data_read, drop_read;
  logic [2:0] pending;

  assign hdr_len      = rd_dat_i[HDR_LEN_LSB +: LEN_W];
  assign hdr_len_p3   = hdr_len + LEN_W'(3);
  assign hdr_words    = hdr_len_p3 >> 2;
  assign hdr_oversize = hdr_len > LEN_W'(MAX_LEN);

  assign buf_valid = (occ != 2'd0);
  assign consume   = buf_valid && Tx_mac_wa;

  // Words held plus the one returning next cycle, less the one leaving now.
  assign pending   = {1'b0, occ} + {2'b00, inflight_q};
  assign can_read  = pending < (3'd2 + {2'b00, consume});
  assign data_read = (state_q == StData) && (reads_left_q != '0) && !rd_empty_i && can_read;
  assign drop_read = (state_q == StDrop) && (reads_left_q != '0) && !rd_empty_i;

  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (rd_ready_i && !rd_empty_i) state_d = StHdr;
      StHdr: begin
        if (hdr_len == '0)     state_d = StDone;
        else if (hdr_oversize) state_d = StDrop;
        else                   state_d = StData;
      end
      StData: if (consume && sent_left_q == LEN_W'(1)) state_d = StDone;
      StDrop: begin
        if (reads_left_q == '0 || (drop_read && reads_left_q == LEN_W'(1))) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_read_o = 1'b0;
    rd_done_o = 1'b0;
    err_o     = 1'b0;
    unique case (state_q)
      StIdle:  rd_read_o = rd_ready_i && !rd_empty_i && !Reset;
      StHdr:   err_o     = hdr_oversize && (hdr_len != '0);
      StData:  rd_read_o = data_read;
      StDrop:  rd_read_o = drop_read;
      StDone:  rd_done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      len_lsb_q    <= 2'd0;
      words_q      <= '0;
      reads_left_q <= '0;
      sent_left_q  <= '0;
      inflight_q   <= 1'b0;
      inf_sop_q    <= 1'b0;
      inf_eop_q    <= 1'b0;
    end else begin
      if (state_q == StHdr) begin
        len_lsb_q    <= hdr_len[1:0];
        words_q      <= hdr_words;
        reads_left_q <= hdr_words;
        sent_left_q  <= hdr_words;
      end else begin
        if (data_read || drop_read) reads_left_q <= reads_left_q - LEN_W'(1);
        if (consume)                sent_left_q  <= sent_left_q - LEN_W'(1);
      end
      // Frame position is tagged at issue time and travels with the returning word.
      inflight_q <= data_read;
      inf_sop_q  <= data_read && (reads_left_q == words_q);
      inf_eop_q  <= data_read && (reads_left_q == LEN_W'(1));
    end
  end

  always_comb begin
    push_word.data = rd_dat_i;
    push_word.sop  = inf_sop_q;
    push_word.eop  = inf_eop_q;
    push_word.be   = inf_eop_q ? be_for_len(len_lsb_q) : BE_4;
  end

  tx_skid2 u_skid (
    .clk_i       (Clk_user),
    .rst_i       (Reset),
    .push_i      (inflight_q),
    .push_word_i (push_word),
    .pop_i       (consume),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign Tx_mac_wr   = consume;
  assign Tx_mac_data = buf_valid ? head.data : '0;
  assign Tx_mac_sop  = buf_valid && head.sop;
  assign Tx_mac_eop  = buf_valid && head.eop;
  assign Tx_mac_BE   = buf_valid ? head.be : 2'b00;

endmodule

// File: tb/tb_mac_tx_fifo_reader.sv
// Scoreboard bench: a queue-backed packet FIFO feeds the reader, expected MAC words are queued.
module tb_mac_tx_fifo_reader;

  logic        Clk_user = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] rd_dat_i = '0;
  logic        rd_read_o, rd_done_o;
  logic        rd_ready_i = 1'b0;
  logic        rd_empty_i = 1'b1;
  logic        Tx_mac_wa = 1'b1;
  logic        Tx_mac_wr;
  logic [31:0] Tx_mac_data;
  logic [1:0]  Tx_mac_BE;
  logic        Tx_mac_sop, Tx_mac_eop, err_o;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  be;
  } exp_t;

  logic [31:0] fifo_q[$];
  exp_t        exp_q[$];
  int          wr_cyc[$];
  int n_checks = 0, n_fail = 0;
  int n_rd = 0, n_wr = 0, n_done = 0, n_err = 0, n_sop = 0, n_eop = 0, cyc = 0;
  logic pop_s = 1'b0;

  always #5 Clk_user = ~Clk_user;

  mac_tx_fifo_reader dut (
    .Clk_user    (Clk_user),
    .Reset       (Reset),
    .rd_dat_i    (rd_dat_i),
    .rd_read_o   (rd_read_o),
    .rd_done_o   (rd_done_o),
    .rd_ready_i  (rd_ready_i),
    .rd_empty_i  (rd_empty_i),
    .Tx_mac_wa   (Tx_mac_wa),
    .Tx_mac_wr   (Tx_mac_wr),
    .Tx_mac_data (Tx_mac_data),
    .Tx_mac_BE   (Tx_mac_BE),
    .Tx_mac_sop  (Tx_mac_sop),
    .Tx_mac_eop  (Tx_mac_eop),
    .err_o       (err_o)
  );

  // Monitor and scoreboard: sample away from the active edge.
  always @(negedge Clk_user) begin
    exp_t e;
    pop_s = rd_read_o;
    cyc++;
    if (rd_read_o) begin
      n_rd++;
      if (fifo_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL fifo_underflow: read issued at cycle %0d with FIFO empty", cyc);
      end
    end
    if (rd_done_o) n_done++;
    if (err_o) n_err++;
    if (Tx_mac_wr) begin
      n_wr++;
      wr_cyc.push_back(cyc);
      if (Tx_mac_sop) n_sop++;
      if (Tx_mac_eop) n_eop++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got data=%h sop=%b eop=%b be=%b, expected no write",
                 Tx_mac_data, Tx_mac_sop, Tx_mac_eop, Tx_mac_BE);
      end else begin
        e = exp_q.pop_front();
        if ({Tx_mac_data, Tx_mac_sop, Tx_mac_eop, Tx_mac_BE} !== e) begin
          n_fail++;
          $display("FAIL sb_word: got data=%h sop=%b eop=%b be=%b, expected data=%h sop=%b eop=%b be=%b",
                   Tx_mac_data, Tx_mac_sop, Tx_mac_eop, Tx_mac_BE, e.data, e.sop, e.eop, e.be);
        end
      end
    end
  end

  // Packet FIFO model: data appears one cycle after the pop strobe.
  always @(posedge Clk_user) begin
    #1;
    if (pop_s && fifo_q.size() != 0) rd_dat_i = fifo_q.pop_front();
    rd_empty_i = (fifo_q.size() == 0);
    rd_ready_i = (fifo_q.size() != 0);
  end

  function automatic logic [1:0] be_exp(input int len);
    case (len % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic load_frame(input int len, input bit expect_out);
    int          words;
    logic [31:0] w;
    exp_t        e;
    words = (len + 3) / 4;
    fifo_q.push_back({16'($urandom), 16'(len)});
    for (int i = 0; i < words; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      if (expect_out) begin
        e.data = w;
        e.sop  = (i == 0);
        e.eop  = (i == words - 1);
        e.be   = (i == words - 1) ? be_exp(len) : 2'b00;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(posedge Clk_user);
    #2;
    n_checks++;
    if ({rd_read_o, rd_done_o, Tx_mac_wr, Tx_mac_sop, Tx_mac_eop, err_o, Tx_mac_BE, Tx_mac_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%b done=%b wr=%b sop=%b eop=%b err=%b be=%b data=%h, expected all 0",
               rd_read_o, rd_done_o, Tx_mac_wr, Tx_mac_sop, Tx_mac_eop, err_o, Tx_mac_BE, Tx_mac_data);
    end
    load_frame(8, 1'b0);
    repeat (2) @(posedge Clk_user);
    #2;
    n_checks++;
    if (rd_read_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_read: got rd_read_o=%b with frame ready, expected 0", rd_read_o);
    end
    fifo_q.delete();
    repeat (2) @(posedge Clk_user);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clk_user);
  endtask

  task automatic test_frame64;
    int r0 = n_rd, w0 = n_wr, d0 = n_done, s0 = n_sop, e0 = n_eop, idx = wr_cyc.size(), span;
    load_frame(64, 1'b1);
    for (int c = 0; c < 500 && n_done == d0; c++) @(posedge Clk_user);
    repeat (4) @(posedge Clk_user);
    span = (wr_cyc.size() >= idx + 16) ? wr_cyc[idx + 15] - wr_cyc[idx] : -1;
    n_checks += 6;
    if (n_wr - w0 !== 16) begin n_fail++; $display("FAIL f64_writes: got %0d, expected 16", n_wr - w0); end
    if (n_rd - r0 !== 17) begin n_fail++; $display("FAIL f64_reads: got %0d, expected 17", n_rd - r0); end
    if (n_done - d0 !== 1) begin n_fail++; $display("FAIL f64_done: got %0d, expected 1", n_done - d0); end
    if (n_sop - s0 !== 1) begin n_fail++; $display("FAIL f64_sop: got %0d, expected 1", n_sop - s0); end
    if (n_eop - e0 !== 1) begin n_fail++; $display("FAIL f64_eop: got %0d, expected 1", n_eop - e0); end
    if (span !== 15) begin n_fail++; $display("FAIL f64_back_to_back: span %0d cycles, expected 15", span); end
  endtask

  task automatic test_frame61;
    int w0 = n_wr, d0 = n_done;
    load_frame(61, 1'b1);
    for (int c = 0; c < 500 && n_done == d0; c++) @(posedge Clk_user);
    repeat (4) @(posedge Clk_user);
    n_checks += 3;
    if (n_wr - w0 !== 16) begin n_fail++; $display("FAIL f61_writes: got %0d, expected 16", n_wr - w0); end
    if (n_done - d0 !== 1) begin n_fail++; $display("FAIL f61_done: got %0d, expected 1", n_done - d0); end
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL f61_leftover: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_stall;
    int r0 = n_rd, w0 = n_wr, d0 = n_done, max_out = 0, out_now;
    load_frame(64, 1'b1);
    for (int c = 1; c < 600 && n_done == d0; c++) begin
      @(posedge Clk_user);
      #1;
      Tx_mac_wa = !((c >= 3 && c <= 7) || (c >= 14 && c <= 22 && $urandom_range(0, 1) == 0));
      out_now = (n_rd - r0 > 0) ? (n_rd - r0 - 1) - (n_wr - w0) : 0;
      if (out_now > max_out) max_out = out_now;
    end
    Tx_mac_wa = 1'b1;
    repeat (4) @(posedge Clk_user);
    n_checks += 3;
    if (n_wr - w0 !== 16) begin n_fail++; $display("FAIL stall_writes: got %0d, expected 16", n_wr - w0); end
    if (n_done - d0 !== 1) begin n_fail++; $display("FAIL stall_done: got %0d, expected 1", n_done - d0); end
    if (max_out !== 2) begin n_fail++; $display("FAIL stall_outstanding: max %0d, expected 2", max_out); end
  endtask

  task automatic test_oversize;
    int r0 = n_rd, w0 = n_wr, d0 = n_done, x0 = n_err;
    load_frame(3000, 1'b0);
    for (int c = 0; c < 2000 && n_done == d0; c++) @(posedge Clk_user);
    repeat (4) @(posedge Clk_user);
    n_checks += 4;
    if (n_err - x0 !== 1) begin n_fail++; $display("FAIL drop_err: got %0d, expected 1", n_err - x0); end
    if (n_rd - r0 !== 751) begin n_fail++; $display("FAIL drop_reads: got %0d, expected 751", n_rd - r0); end
    if (n_wr - w0 !== 0) begin n_fail++; $display("FAIL drop_writes: got %0d, expected 0", n_wr - w0); end
    if (n_done - d0 !== 1) begin n_fail++; $display("FAIL drop_done: got %0d, expected 1", n_done - d0); end
    w0 = n_wr;
    d0 = n_done;
    load_frame(8, 1'b1);
    for (int c = 0; c < 500 && n_done == d0; c++) @(posedge Clk_user);
    repeat (4) @(posedge Clk_user);
    n_checks += 2;
    if (n_wr - w0 !== 2) begin n_fail++; $display("FAIL after_drop_writes: got %0d, expected 2", n_wr - w0); end
    if (n_err - x0 !== 1) begin n_fail++; $display("FAIL after_drop_err: got %0d, expected 1", n_err - x0); end
  endtask

  task automatic test_back_to_back;
    int w0 = n_wr, d0 = n_done, s0 = n_sop, e0 = n_eop;
    load_frame(1, 1'b1);
    load_frame(4, 1'b1);
    for (int c = 0; c < 500 && n_done - d0 < 2; c++) @(posedge Clk_user);
    repeat (4) @(posedge Clk_user);
    n_checks += 4;
    if (n_wr - w0 !== 2) begin n_fail++; $display("FAIL b2b_writes: got %0d, expected 2", n_wr - w0); end
    if (n_sop - s0 !== 2) begin n_fail++; $display("FAIL b2b_sop: got %0d, expected 2", n_sop - s0); end
    if (n_eop - e0 !== 2) begin n_fail++; $display("FAIL b2b_eop: got %0d, expected 2", n_eop - e0); end
    if (n_done - d0 !== 2) begin n_fail++; $display("FAIL b2b_done: got %0d, expected 2", n_done - d0); end
  endtask

  task automatic test_reset_mid;
    int w0 = n_wr, d0;
    load_frame(64, 1'b1);
    for (int c = 0; c < 500 && n_wr - w0 < 5; c++) @(posedge Clk_user);
    #1 Reset = 1'b1;
    #1;
    n_checks++;
    if ({rd_read_o, rd_done_o, Tx_mac_wr, Tx_mac_sop, Tx_mac_eop, err_o, Tx_mac_BE, Tx_mac_data} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got rd=%b done=%b wr=%b sop=%b eop=%b err=%b be=%b data=%h, expected all 0",
               rd_read_o, rd_done_o, Tx_mac_wr, Tx_mac_sop, Tx_mac_eop, err_o, Tx_mac_BE, Tx_mac_data);
    end
    @(negedge Clk_user);
    fifo_q.delete();
    exp_q.delete();
    repeat (3) @(posedge Clk_user);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clk_user);
    w0 = n_wr;
    d0 = n_done;
    load_frame(16, 1'b1);
    for (int c = 0; c < 500 && n_done == d0; c++) @(posedge Clk_user);
    repeat (4) @(posedge Clk_user);
    n_checks += 2;
    if (n_wr - w0 !== 4) begin n_fail++; $display("FAIL post_reset_writes: got %0d, expected 4", n_wr - w0); end
    if (n_done - d0 !== 1) begin n_fail++; $display("FAIL post_reset_done: got %0d, expected 1", n_done - d0); end
  endtask

  initial begin
    test_reset();
    test_frame64();
    test_frame61();
    test_stall();
    test_oversize();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL final_scoreboard: got %0d words never sent, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_tx_fifo_reader.md
Name: mac_tx_fifo_reader

Overview:
Drains complete frames from the packet read-FIFO interface and drives the tri-mode MAC's user TX interface (Tx_mac_wa/wr/data/BE/sop/eop). It is the transmit-side counterpart of the MAC's host and RX plumbing, and sits between the packet buffer and MAC_top in the Clk_user domain. Each frame is one 32-bit length header word followed by big-endian payload words. A two-entry output buffer sustains one word per clock while absorbing Tx_mac_wa stalls.

Parameters:
MAX_LEN, 2047, largest legal frame length in bytes; longer frames are discarded.
LEN_W, 16, width of the length field in the header word (rd_dat_i[LEN_W-1:0]).

Ports:
Clk_user  in  1  user clock; all logic is in this domain.
Reset  in  1  asynchronous, active-high reset.
rd_dat_i  in  32  FIFO read data; valid exactly 1 cycle after rd_read_o.
rd_read_o  out  1  FIFO pop strobe, one word per asserted cycle.
rd_done_o  out  1  one-cycle pulse when a frame is fully consumed.
rd_ready_i  in  1  at least one complete frame is present in the FIFO.
rd_empty_i  in  1  FIFO holds no words.
Tx_mac_wa  in  1  MAC can accept a word this cycle.
Tx_mac_wr  out  1  word write strobe to the MAC.
Tx_mac_data  out  32  payload word; byte 0 is in [31:24].
Tx_mac_BE  out  2  valid bytes on eop: 00=4, 01=1, 10=2, 11=3.
Tx_mac_sop  out  1  first word of the frame.
Tx_mac_eop  out  1  last word of the frame.
err_o  out  1  one-cycle pulse when an oversize frame is dropped.

Behaviour:
- Reset: every output is 0; the FSM returns to IDLE; the buffer, counters and in-flight flag are cleared. A frame interrupted by reset is lost. The FIFO owner flushes it; this block does not resynchronise.
- States: IDLE, HDR, DATA, DROP, DONE.
- IDLE: when rd_ready_i and !rd_empty_i, assert rd_read_o for 1 cycle and go to HDR.
- HDR (header word on rd_dat_i):
  - len = rd_dat_i[LEN_W-1:0]; words = (len+3)>>2, computed in LEN_W bits.
  - len==0 -> DONE.
  - len>MAX_LEN -> pulse err_o, go to DROP.
  - Otherwise load reads_left=words and sent_left=words, then go to DATA.
- DATA read issue:
  - Assert rd_read_o when reads_left>0, !rd_empty_i, and (occupancy + inflight - consume) < 2.
  - consume = Tx_mac_wr this cycle.
  - A returned word enters the buffer tail the next cycle.
- DATA write side:
  - Tx_mac_wr = buffer non-empty && Tx_mac_wa; no combinational path from Tx_mac_wa to rd_read_o beyond the consume term.
  - Tx_mac_data, sop, eop and BE reflect the buffer head and stay stable while Tx_mac_wa is low.
  - sop=1 when sent_left==words; eop=1 when sent_left==1.
  - BE=len[1:0] on the eop word and 00 on all other words.
  - When a write occurs with sent_left==1, go to DONE.
- A one-word frame has sop and eop asserted together.
- DROP: pop the header-declared word count at the FIFO rate (empty-gated) with nothing sent to the MAC, then go to DONE.
- DONE: pulse rd_done_o for 1 cycle, then go to IDLE. A new header read cannot start in the same cycle.
- Throughput: with Tx_mac_wa held high and the FIFO non-empty, one word per cycle after a 2-cycle start-up (header, then first data word).
- Simultaneous buffer push and pop: occupancy is unchanged and ordering is preserved.
- rd_empty_i rising mid-frame: reads pause and the output drains. No error is flagged, because rd_ready_i guaranteed a whole frame.

Decomposition:
- Shared package (eth_pkg): MAC BE encoding constants, the FSM state enum, and the header field position constants.
- Sub-module tx_skid2: a two-entry FIFO holding {data, sop, eop, BE} with push/pop/occupancy. The FSM and counters stay in the top module.

Test Plan:
- 64-byte frame, Tx_mac_wa=1 -> 16 consecutive Tx_mac_wr; sop on word 0, eop on word 15, BE=00; one rd_done_o pulse; 17 rd_read_o pulses.
- 61-byte frame -> 16 words, eop word BE=01, data bytes match the FIFO image.
- 64-byte frame with Tx_mac_wa low on cycles 3-7 -> data held stable, no word lost or duplicated, never more than 2 outstanding words.
- Header len=3000 (>MAX_LEN) -> err_o pulse, 750 payload pops, zero Tx_mac_wr, rd_done_o, next frame sent normally.
- Back-to-back 1-byte and 4-byte frames -> each has a single word with sop=eop=1; BE=01 then 00; two rd_done_o pulses.
- Reset asserted mid-frame (word 5 of 16) -> all outputs 0 immediately; after release, FSM in IDLE and the next valid frame sent intact.
